// File: rtl/bitmanip_issue_ctrl.sv
// bitmanip_issue_ctrl: issue controller for the execute-stage bit manipulation unit.
// Accepts one micro-op over req_valid_i/req_ready_o, pulses bmu_enable_o for one cycle
// with the latched op/operands, waits LATENCY cycles, captures bmu_result_i and offers
// it to writeback over wb_valid_o/wb_ready_i. Illegal op codes (>= NUM_OPS) skip the
// unit and write back zero with wb_illegal_o set. flush_i aborts any in-flight op.
// Ports:
//   clk_i, rst_i (async, active-high), flush_i
//   req_valid_i/req_ready_o, req_op_i, req_rs1_i, req_rs2_i, req_rd_i   upstream op
//   bmu_enable_o, bmu_op_o, bmu_operand1_o, bmu_operand2_o, bmu_result_i unit side
//   wb_valid_o/wb_ready_i, wb_rd_o, wb_data_o, wb_illegal_o             writeback
//   busy_o                                                             op in flight
module bitmanip_issue_ctrl #(
    parameter int XLEN    = 32,
    parameter int OP_W    = 5,
    parameter int NUM_OPS = 23,
    parameter int LATENCY = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [OP_W-1:0] req_op_i,
    input  logic [XLEN-1:0] req_rs1_i,
    input  logic [XLEN-1:0] req_rs2_i,
    input  logic [4:0]      req_rd_i,
    output logic            bmu_enable_o,
    output logic [OP_W-1:0] bmu_op_o,
    output logic [XLEN-1:0] bmu_operand1_o,
    output logic [XLEN-1:0] bmu_operand2_o,
    input  logic [XLEN-1:0] bmu_result_i,
    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            wb_illegal_o,
    output logic            busy_o
);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d, data_q, data_d;
    logic [4:0]      rd_q, rd_d;
    logic            ill_q, ill_d, en_q, en_d, valid_q, valid_d, busy_q, busy_d;
    logic            accept;

    // Ready is combinational so a new op can ride the same edge as the writeback handshake;
    // it is held low during reset so every output reads 0 while rst_i is asserted.
    assign req_ready_o = ~rst_i & ~flush_i & ((state_q == IDLE) | ((state_q == DONE) & wb_ready_i));
    assign accept      = req_valid_i & req_ready_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        data_d  = data_q;
        ill_d   = ill_q;
        case (state_q)
            ISSUE: begin
                cnt_d   = CW'(LATENCY);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    data_d  = bmu_result_i;
                    ill_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = wb_ready_i ? IDLE : DONE;
            default: ;
        endcase
        if (accept) begin
            op_d  = req_op_i;
            rs1_d = req_rs1_i;
            rs2_d = req_rs2_i;
            rd_d  = req_rd_i;
            if (32'(req_op_i) < NUM_OPS) begin
                state_d = ISSUE;
            end else begin
                // Illegal ops never reach the unit; they write back zero straight away.
                data_d  = '0;
                ill_d   = 1'b1;
                state_d = DONE;
            end
        end
        if (flush_i) state_d = IDLE;
        // Status outputs are registered from the next state so they align with state_q.
        en_d    = state_d == ISSUE;
        valid_d = state_d == DONE;
        busy_d  = state_d != IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            ill_q   <= 1'b0;
            en_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            ill_q   <= ill_d;
            en_q    <= en_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bmu_enable_o   = en_q;
    assign bmu_op_o       = op_q;
    assign bmu_operand1_o = rs1_q;
    assign bmu_operand2_o = rs2_q;
    assign wb_valid_o     = valid_q;
    assign wb_rd_o        = rd_q;
    assign wb_data_o      = data_q;
    assign wb_illegal_o   = ill_q;
    assign busy_o         = busy_q;
endmodule

// File: tb/tb_bitmanip_issue_ctrl.sv
// tb_bitmanip_issue_ctrl: scoreboard bench for bitmanip_issue_ctrl at LATENCY 2, 3 and 1.
module tb_bitmanip_issue_ctrl;
    typedef struct {
        int          inst;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ill;
    } exp_t;

    logic        clk, rst, flush, wbr;
    logic [4:0]  op, rd;
    logic [31:0] rs1, rs2;
    logic        rv[3], ready[3], en[3], wv[3], wil[3], busy[3];
    logic [4:0]  bop[3], wrd[3];
    logic [31:0] o1[3], o2[3], wd[3], res[3];
    exp_t        sb[$];
    int          n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        return (o == 5'd1) ? (a | b) : (a + b);
    endfunction

    initial clk = 0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int L = (g == 0) ? 2 : (g == 1) ? 3 : 1;
        logic [31:0] pipe[L];
        int          en_cnt = 0;
        exp_t        e;
        bitmanip_issue_ctrl #(.LATENCY(L)) dut (
            .clk_i(clk), .rst_i(rst), .flush_i(flush),
            .req_valid_i(rv[g]), .req_ready_o(ready[g]),
            .req_op_i(op), .req_rs1_i(rs1), .req_rs2_i(rs2), .req_rd_i(rd),
            .bmu_enable_o(en[g]), .bmu_op_o(bop[g]),
            .bmu_operand1_o(o1[g]), .bmu_operand2_o(o2[g]), .bmu_result_i(res[g]),
            .wb_valid_o(wv[g]), .wb_ready_i(wbr), .wb_rd_o(wrd[g]),
            .wb_data_o(wd[g]), .wb_illegal_o(wil[g]), .busy_o(busy[g])
        );
        assign res[g] = pipe[L-1];
        // Unit model: result appears L cycles after the enable cycle; garbage otherwise.
        always @(posedge clk) begin
            pipe[0] <= en[g] ? model(bop[g], o1[g], o2[g]) : 32'hDEAD_BEEF;
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        always @(negedge clk) begin
            if (en[g]) en_cnt++;
            if (!rst && wv[g] && wbr) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL wb_unexpected: inst %0d rd %0d data %h, expected no writeback", g, wrd[g], wd[g]);
                end else begin
                    e = sb.pop_front();
                    check("wb_inst", 32'(g), 32'(e.inst));
                    check("wb_rd", 32'(wrd[g]), 32'(e.rd));
                    check("wb_data", wd[g], e.data);
                    check("wb_illegal", 32'(wil[g]), 32'(e.ill));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        bit seen;
        rst = 0; flush = 0; wbr = 0; op = 0; rd = 0; rs1 = 0; rs2 = 0;
        foreach (rv[i]) rv[i] = 0;
        #2 rst = 1;
        #1;
        check("rst_busy", 32'(busy[0]), 0);
        check("rst_valid", 32'(wv[0]), 0);
        check("rst_enable", 32'(en[0]), 0);
        check("rst_ready", 32'(ready[0]), 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #1 check("post_rst_ready", 32'(ready[0]), 1);

        // Basic op and writeback stall, LATENCY=2
        step();
        op = 1; rs1 = 32'hF0; rs2 = 32'h0F; rd = 7; rv[0] = 1;
        sb.push_back('{0, 5'd7, 32'hFF, 1'b0});
        @(negedge clk) check("basic_ready", 32'(ready[0]), 1);
        step();
        rv[0] = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("basic_enable", 32'(en[0]), 32'(k == 1));
            check("basic_valid_early", 32'(wv[0]), 0);
            if (k == 1) begin
                check("basic_bmu_op", 32'(bop[0]), 1);
                check("basic_operand1", o1[0], 32'hF0);
                check("basic_operand2", o2[0], 32'h0F);
            end
            step();
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", 32'(wv[0]), 1);
            check("stall_data", wd[0], 32'hFF);
            check("stall_rd", 32'(wrd[0]), 7);
            check("stall_ready", 32'(ready[0]), 0);
            check("stall_busy", 32'(busy[0]), 1);
            step();
        end
        wbr = 1;
        @(negedge clk) check("done_ready", 32'(ready[0]), 1);
        step();
        wbr = 0;
        @(negedge clk);
        check("release_idle_busy", 32'(busy[0]), 0);
        check("release_idle_valid", 32'(wv[0]), 0);
        check("basic_en_count", 32'(g_inst[0].en_cnt), 1);

        // Illegal op
        step();
        op = 5'd30; rs1 = 32'd123; rd = 9; rv[0] = 1;
        sb.push_back('{0, 5'd9, 32'h0, 1'b1});
        step();
        rv[0] = 0;
        @(negedge clk);
        check("illegal_valid", 32'(wv[0]), 1);
        check("illegal_flag", 32'(wil[0]), 1);
        check("illegal_data", wd[0], 0);
        check("illegal_enable", 32'(en[0]), 0);
        step();
        wbr = 1;
        @(negedge clk);
        step();
        wbr = 0;
        @(negedge clk) check("illegal_idle", 32'(wv[0]), 0);
        check("illegal_en_count", 32'(g_inst[0].en_cnt), 1);

        // Flush in WAIT, LATENCY=3
        step();
        op = 2; rs1 = 1; rs2 = 1; rd = 5; rv[1] = 1;
        step();
        rv[1] = 0;
        @(negedge clk) check("flush_issue_enable", 32'(en[1]), 1);
        step();
        step();
        flush = 1; rv[1] = 1; op = 3; rd = 6; wbr = 1;
        @(negedge clk);
        check("flush_ready", 32'(ready[1]), 0);
        check("flush_busy", 32'(busy[1]), 1);
        step();
        flush = 0; rv[1] = 0;
        @(negedge clk);
        check("flush_idle_busy", 32'(busy[1]), 0);
        check("flush_idle_valid", 32'(wv[1]), 0);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            @(negedge clk) if (wv[1]) cnt++;
        end
        check("flush_no_wb", 32'(cnt), 0);
        check("flush_en_count", 32'(g_inst[1].en_cnt), 1);
        wbr = 0;

        // Back-to-back, LATENCY=1
        step();
        wbr = 1; op = 2; rs1 = 10; rs2 = 5; rd = 3; rv[2] = 1;
        sb.push_back('{2, 5'd3, 32'h0000000F, 1'b0});
        sb.push_back('{2, 5'd4, 32'h00000123, 1'b0});
        step();
        op = 3; rs1 = 32'h100; rs2 = 32'h23; rd = 4;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check("b2b_valid", 32'(wv[2]), 32'(k == 3 || k == 6));
            check("b2b_enable", 32'(en[2]), 32'(k == 1 || k == 4));
            if (k == 3) check("b2b_ready_in_done", 32'(ready[2]), 1);
            step();
            if (k == 3) rv[2] = 0;
        end
        wbr = 0;
        check("b2b_en_count", 32'(g_inst[2].en_cnt), 2);

        // Async reset mid-WAIT, LATENCY=2
        op = 4; rs1 = 1; rs2 = 2; rd = 12; rv[0] = 1;
        step();
        rv[0] = 0;
        step();
        @(negedge clk);
        #2 rst = 1;
        #1;
        check("arst_busy", 32'(busy[0]), 0);
        check("arst_enable", 32'(en[0]), 0);
        check("arst_valid", 32'(wv[0]), 0);
        check("arst_ready", 32'(ready[0]), 0);
        check("arst_op", 32'(bop[0]), 0);
        check("arst_operands", o1[0] | o2[0], 0);
        check("arst_wb", wd[0] | 32'(wrd[0]) | 32'(wil[0]), 0);
        #1 rst = 0;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk) if (wv[0]) cnt++;
        end
        check("arst_no_wb", 32'(cnt), 0);
        step();
        wbr = 1; rv[0] = 1;
        sb.push_back('{0, 5'd12, 32'h3, 1'b0});
        step();
        rv[0] = 0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (wv[0]) begin
                seen = 1;
                break;
            end
        end
        check("arst_recover_wb", 32'(seen), 1);
        step();
        wbr = 0;
        step();
        check("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
